// File: rtl/bot_feeder.sv
// Bot feeder: filters zero-mask bots, tags survivors with a sequence index and
// writes them into the input module FIFO, throttled by usedw plus in-flight writes.
module bot_feeder #(
  parameter int EXTRA_DATA_WIDTH      = 12,
  parameter int FULLNESS_LATENCY      = 3,
  parameter int ALMOST_FULL_THRESHOLD = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [127:0]                botIn,
  input  logic                        botInValid,
  input  logic [5:0]                  validBotPermutesIn,
  output logic                        botInReady,
  input  logic [4:0]                  fifoFullness,
  output logic [127:0]                botOut,
  output logic                        anyBotPermutIsValid,
  output logic [5:0]                  validBotPermutesOut,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataOut,
  output logic [31:0]                 botsIssued,
  output logic [31:0]                 botsDropped
);

  localparam int SW = 7;

  logic [FULLNESS_LATENCY-1:0] hist_q, hist_d;
  logic [EXTRA_DATA_WIDTH-1:0] tag_q, tag_d;
  logic [31:0]                 issued_q, issued_d;
  logic [31:0]                 dropped_q, dropped_d;
  logic [127:0]                bot_q, bot_d;
  logic [5:0]                  mask_q, mask_d;
  logic [EXTRA_DATA_WIDTH-1:0] xtra_q, xtra_d;

  logic [SW-1:0] credit_sum;
  logic          acc;
  logic          wr;
  logic          drop;

  // hist_q[0] is the write strobe itself; older entries are writes usedw has not caught up with.
  always_comb begin
    credit_sum = SW'(fifoFullness);
    for (int i = 0; i < FULLNESS_LATENCY; i++) begin
      credit_sum = credit_sum + SW'(hist_q[i]);
    end
  end

  assign botInReady = !rst && (credit_sum < SW'(ALMOST_FULL_THRESHOLD));
  assign acc        = botInValid && botInReady;
  assign wr         = acc && (validBotPermutesIn != 6'd0);
  assign drop       = acc && (validBotPermutesIn == 6'd0);

  always_comb begin
    hist_d    = '0;
    hist_d[0] = wr;
    for (int i = 1; i < FULLNESS_LATENCY; i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  always_comb begin
    tag_d     = tag_q;
    issued_d  = issued_q;
    dropped_d = dropped_q;
    bot_d     = bot_q;
    mask_d    = mask_q;
    xtra_d    = xtra_q;
    if (wr) begin
      tag_d  = tag_q + 1'b1;
      bot_d  = botIn;
      mask_d = validBotPermutesIn;
      xtra_d = tag_q;
      if (issued_q != 32'hFFFF_FFFF) begin
        issued_d = issued_q + 32'd1;
      end
    end
    if (drop && dropped_q != 32'hFFFF_FFFF) begin
      dropped_d = dropped_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q    <= '0;
      tag_q     <= '0;
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      hist_q    <= hist_d;
      tag_q     <= tag_d;
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
    end
  end

  // Payload is qualified by the strobe, so it needs no reset.
  always_ff @(posedge clk) begin
    bot_q  <= bot_d;
    mask_q <= mask_d;
    xtra_q <= xtra_d;
  end

  assign anyBotPermutIsValid = hist_q[0];
  assign botOut              = bot_q;
  assign validBotPermutesOut = mask_q;
  assign extraDataOut        = xtra_q;
  assign botsIssued          = issued_q;
  assign botsDropped         = dropped_q;

endmodule

// File: tb/tb_bot_feeder.sv
// Directed bench for bot_feeder: reset, streaming, drop, throttle/drain against a
// delayed-usedw FIFO model, tag wrap on a 4-bit-tag instance, and reset mid-stream.
module tb_bot_feeder;
  localparam int THR = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] botIn;
  logic         botInValid;
  logic [5:0]   validBotPermutesIn;
  logic [4:0]   fifoFullness;

  logic         botInReady, anyBotPermutIsValid;
  logic [127:0] botOut;
  logic [5:0]   validBotPermutesOut;
  logic [11:0]  extraDataOut;
  logic [31:0]  botsIssued, botsDropped;

  logic         rdy_w4, strobe_w4;
  logic [127:0] bot_w4;
  logic [5:0]   mask_w4;
  logic [3:0]   tag_w4;
  logic [31:0]  issued_w4, dropped_w4;

  bot_feeder #(.EXTRA_DATA_WIDTH(12), .FULLNESS_LATENCY(3), .ALMOST_FULL_THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst), .botIn(botIn), .botInValid(botInValid),
    .validBotPermutesIn(validBotPermutesIn), .botInReady(botInReady),
    .fifoFullness(fifoFullness), .botOut(botOut), .anyBotPermutIsValid(anyBotPermutIsValid),
    .validBotPermutesOut(validBotPermutesOut), .extraDataOut(extraDataOut),
    .botsIssued(botsIssued), .botsDropped(botsDropped)
  );

  bot_feeder #(.EXTRA_DATA_WIDTH(4), .FULLNESS_LATENCY(3), .ALMOST_FULL_THRESHOLD(THR)) dut_w4 (
    .clk(clk), .rst(rst), .botIn(botIn), .botInValid(botInValid),
    .validBotPermutesIn(validBotPermutesIn), .botInReady(rdy_w4),
    .fifoFullness(fifoFullness), .botOut(bot_w4), .anyBotPermutIsValid(strobe_w4),
    .validBotPermutesOut(mask_w4), .extraDataOut(tag_w4),
    .botsIssued(issued_w4), .botsDropped(dropped_w4)
  );

  // FIFO environment: a write shows up in usedw three cycles after its strobe.
  logic hold_zero, pop, env_clr, d1, d2;
  int   fifo_cnt, npops;
  assign fifoFullness = hold_zero ? 5'd0 : 5'(fifo_cnt);

  always @(posedge clk) begin
    if (env_clr) begin
      d1 <= 1'b0; d2 <= 1'b0; fifo_cnt <= 0; npops <= 0;
    end else begin
      d1 <= anyBotPermutIsValid;
      d2 <= d1;
      if (pop && fifo_cnt > 0) begin
        fifo_cnt <= fifo_cnt + int'(d2) - 1;
        npops    <= npops + 1;
      end else begin
        fifo_cnt <= fifo_cnt + int'(d2);
      end
    end
  end

  int n_chk = 0, n_err = 0;
  int tag_ctr, nwrites, exp_issued, exp_dropped, obs_writes, max_full;
  logic         pend_vld, pend_wr;
  int           pend_tag;
  logic [127:0] pend_bot;
  logic [5:0]   pend_mask;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [5:0] m, input logic [127:0] b);
    logic exp_rdy, a;
    @(negedge clk);
    if (pend_vld) begin
      check_eq("strobe", anyBotPermutIsValid, pend_wr);
      check_eq("strobe_w4", strobe_w4, pend_wr);
      obs_writes += int'(anyBotPermutIsValid);
      if (pend_wr) begin
        check_eq("tag", extraDataOut, 128'(pend_tag % 4096));
        check_eq("tag_w4", tag_w4, 128'(pend_tag % 16));
        check_eq("bot", botOut, pend_bot);
        check_eq("bot_w4", bot_w4, pend_bot);
        check_eq("mask", validBotPermutesOut, pend_mask);
        check_eq("mask_w4", mask_w4, pend_mask);
      end
      check_eq("issued", botsIssued, exp_issued);
      check_eq("dropped", botsDropped, exp_dropped);
    end
    botInValid = v; validBotPermutesIn = m; botIn = b;
    #1;
    exp_rdy = hold_zero ? 1'b1 : ((nwrites - npops) < THR);
    check_eq("ready", botInReady, exp_rdy);
    check_eq("ready_w4", rdy_w4, exp_rdy);
    if (!hold_zero && int'(fifoFullness) > max_full) max_full = int'(fifoFullness);
    a = v && exp_rdy;
    pend_vld = 1'b1; pend_wr = a && (m != 6'd0);
    pend_tag = tag_ctr; pend_bot = b; pend_mask = m;
    if (pend_wr) begin
      tag_ctr++; nwrites++; exp_issued++;
    end else if (a) begin
      exp_dropped++;
    end
  endtask

  task automatic do_reset(input logic hz);
    @(negedge clk);
    if (pend_vld) check_eq("pre_rst_strobe", anyBotPermutIsValid, pend_wr);
    rst = 1'b1; env_clr = 1'b1; hold_zero = hz; pop = 1'b0;
    botInValid = 1'b1; validBotPermutesIn = 6'h3F; botIn = {4{32'hDEAD_BEEF}};
    #1 check_eq("rst_ready", botInReady, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_eq("rst_ready", botInReady, 1'b0);
      check_eq("rst_strobe", anyBotPermutIsValid, 1'b0);
      check_eq("rst_issued", botsIssued, 0);
      check_eq("rst_dropped", botsDropped, 0);
    end
    rst = 1'b0; env_clr = 1'b0; botInValid = 1'b0;
    pend_vld = 1'b0; tag_ctr = 0; nwrites = 0; exp_issued = 0; exp_dropped = 0;
    obs_writes = 0; max_full = 0;
  endtask

  initial begin
    rst = 1'b1; env_clr = 1'b1; hold_zero = 1'b1; pop = 1'b0;
    botInValid = 1'b0; validBotPermutesIn = '0; botIn = '0;
    pend_vld = 1'b0; pend_wr = 1'b0; pend_tag = 0; pend_bot = '0; pend_mask = '0;
    tag_ctr = 0; nwrites = 0; exp_issued = 0; exp_dropped = 0; obs_writes = 0; max_full = 0;

    // Streaming with usedw pinned at zero
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 6'h3F, {4{32'hA000_0000 + 32'(i)}});
    step(1'b0, 6'h3F, '0);
    check_eq("stream_writes", obs_writes, 10);
    check_eq("stream_issued", botsIssued, 10);

    // Zero-mask drop
    do_reset(1'b1);
    step(1'b1, 6'b000001, {4{32'h1111_0001}});
    step(1'b1, 6'b000000, {4{32'h2222_0002}});
    step(1'b1, 6'b100000, {4{32'h3333_0003}});
    step(1'b0, 6'h00, '0);
    check_eq("drop_writes", obs_writes, 2);
    check_eq("drop_count", botsDropped, 1);
    check_eq("drop_count_w4", dropped_w4, 1);

    // Throttle: no pops, continuous source
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 6'h3F, {4{32'hB000_0000 + 32'(i)}});
    for (int i = 0; i < 5; i++) step(1'b0, 6'h3F, '0);
    check_eq("throttle_writes", obs_writes, 24);
    check_eq("throttle_peak", max_full, 24);
    check_eq("throttle_ready", botInReady, 1'b0);

    // Drain: one pop per cycle, source keeps pushing
    pop = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1, 6'h3F, {4{32'hC000_0000 + 32'(i)}});
    step(1'b0, 6'h3F, '0);
    pop = 1'b0;
    check_eq("drain_resumed", obs_writes > 24, 1'b1);
    check_eq("drain_full_le28", max_full <= 28, 1'b1);

    // Tag wrap on the 4-bit instance
    do_reset(1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 6'h3F, {4{32'hD000_0000 + 32'(i)}});
    step(1'b0, 6'h3F, '0);
    check_eq("wrap_issued_w4", issued_w4, 17);
    check_eq("wrap_last_tag_w4", tag_w4, 0);

    // Reset with a strobe pending, then the first bot restarts at tag 0
    step(1'b1, 6'h0F, {4{32'hE000_0001}});
    step(1'b1, 6'h0F, {4{32'hE000_0002}});
    do_reset(1'b1);
    step(1'b1, 6'h0F, {4{32'hF000_0001}});
    step(1'b0, 6'h0F, '0);
    check_eq("post_rst_issued", botsIssued, 1);
    check_eq("post_rst_tag", extraDataOut, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
